// File: rtl/sig_namea_unpack.sv
// Replays one captured SIG_NAMEA word (plus its SIG_NAMEB sideband) as NBEATS narrow beats,
// lower slice first, tagging each beat with the slice it came from.
module sig_namea_unpack #(
   parameter int WIDE_W = 224,
   parameter int SPLIT  = 128,
   parameter int BEAT_W = 32,
   parameter int FOO    = 8,
   parameter int IDX_W  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDE_W-1:0]   SIG_NAMEA,
   input  logic [FOO*4-2:0]    SIG_NAMEB,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BEAT_W-1:0]   out_data,
   output logic [FOO*4-2:0]    out_tag,
   output logic [IDX_W-1:0]    out_idx,
   output logic                out_upper,
   output logic                out_first,
   output logic                out_last,
   output logic [15:0]         word_count
);

   localparam int NBEATS    = WIDE_W / BEAT_W;
   localparam int LOW_BEATS = SPLIT / BEAT_W;
   localparam int NSLOTS    = 2 ** IDX_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);
   localparam logic [IDX_W-1:0] LOW_IDX  = IDX_W'(LOW_BEATS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [WIDE_W-1:0]   data_reg, data_next;
   logic [FOO*4-2:0]    tag_reg, tag_next;
   logic [15:0]         word_count_reg, word_count_next;

   logic                capture;
   logic                beat_xfer;

   // Beat slots beyond NBEATS exist only so every idx value selects something defined.
   logic [BEAT_W-1:0]   beat_slot [NSLOTS];

   genvar gi;
   generate
      for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
         if (gi < NBEATS) begin : g_used
            assign beat_slot[gi] = data_reg[gi*BEAT_W +: BEAT_W];
         end else begin : g_unused
            assign beat_slot[gi] = '0;
         end
      end
   endgenerate

   assign out_valid  = (state_reg == SEND);
   assign out_data   = beat_slot[idx_reg];
   assign out_tag    = tag_reg;
   assign out_idx    = idx_reg;
   assign out_upper  = (idx_reg >= LOW_IDX);
   assign out_first  = (idx_reg == '0);
   assign out_last   = (idx_reg == LAST_IDX);
   assign word_count = word_count_reg;

   // Accepting a new word on the last-beat transfer gives zero-bubble back-to-back words.
   assign in_ready  = !reset &&
                      ((state_reg == IDLE) ||
                       ((state_reg == SEND) && out_last && out_ready));
   assign capture   = in_valid && in_ready;
   assign beat_xfer = out_valid && out_ready;

   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      data_next       = data_reg;
      tag_next        = tag_reg;
      word_count_next = word_count_reg;

      case (state_reg)
         IDLE: begin
            if (capture) begin
               data_next  = SIG_NAMEA;
               tag_next   = SIG_NAMEB;
               idx_next   = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (beat_xfer) begin
               if (!out_last) begin
                  idx_next = idx_reg + 1'b1;
               end else begin
                  word_count_next = word_count_reg + 16'd1;
                  idx_next        = '0;
                  if (capture) begin
                     data_next  = SIG_NAMEA;
                     tag_next   = SIG_NAMEB;
                     state_next = SEND;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         data_reg       <= '0;
         tag_reg        <= '0;
         word_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         data_reg       <= data_next;
         tag_reg        <= tag_next;
         word_count_reg <= word_count_next;
      end
   end

endmodule

// File: tb/tb_sig_namea_unpack.sv
// Randomised directed bench for sig_namea_unpack: a word-level reference model predicts
// handshakes, beat contents and the word counter cycle by cycle.
module tb_sig_namea_unpack;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [223:0]   SIG_NAMEA;
   logic [30:0]    SIG_NAMEB;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_data;
   logic [30:0]    out_tag;
   logic [2:0]     out_idx;
   logic           out_upper;
   logic           out_first;
   logic           out_last;
   logic [15:0]    word_count;

   int checks = 0;
   int failures = 0;

   // Reference model state: word in flight, beat position, completed-word count.
   logic [223:0]   wq [$];
   logic [30:0]    tq [$];
   bit             m_busy;
   int             m_k;
   logic [223:0]   m_word;
   logic [30:0]    m_tag;
   logic [15:0]    m_wc;

   sig_namea_unpack dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SIG_NAMEA  (SIG_NAMEA),
      .SIG_NAMEB  (SIG_NAMEB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_idx    (out_idx),
      .out_upper  (out_upper),
      .out_first  (out_first),
      .out_last   (out_last),
      .word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [223:0] rand_word();
      logic [223:0] w;
      for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Drives the queued words through the DUT, one cycle per iteration, checking every output.
   // mode 0: out_ready always 1; mode 1: 1,0,0 repeating; mode 2: random.
   task automatic stream(input int mode, input int limit);
      int  next_in;
      int  cyc;
      bit  offer;
      bit  exp_rdy;
      next_in = 0;
      cyc = 0;
      while ((next_in < wq.size() || m_busy) && cyc < limit) begin
         offer     = (next_in < wq.size());
         in_valid  = offer;
         SIG_NAMEA = offer ? wq[next_in] : rand_word();
         SIG_NAMEB = offer ? tq[next_in] : 31'($urandom);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         exp_rdy = !m_busy || (m_k == 6 && out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, m_busy);
         if (m_busy) begin
            chk("out_data",  out_data,  m_word[m_k*32 +: 32]);
            chk("out_idx",   out_idx,   m_k);
            chk("out_tag",   out_tag,   m_tag);
            chk("out_upper", out_upper, (m_k >= 4));
            chk("out_first", out_first, (m_k == 0));
            chk("out_last",  out_last,  (m_k == 6));
         end
         chk("word_count", word_count, m_wc);
         if (m_busy && out_ready) begin
            if (m_k == 6) begin
               m_busy = 1'b0;
               m_wc   = m_wc + 16'd1;
            end else begin
               m_k++;
            end
         end
         if (offer && exp_rdy) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_word = wq[next_in];
            m_tag  = tq[next_in];
            next_in++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_done_in_budget", (cyc < limit), 1'b1);
      #1;
      chk("word_count_after_stream", word_count, m_wc);
      wq.delete();
      tq.delete();
   endtask

   initial begin
      logic [223:0] w;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      SIG_NAMEA = '0;
      SIG_NAMEB = '0;
      m_busy    = 1'b0;
      m_k       = 0;
      m_wc      = 16'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_valid",  out_valid,  1'b0);
      chk("reset_in_ready",   in_ready,   1'b0);
      chk("reset_word_count", word_count, 16'd0);
      chk("reset_out_idx",    out_idx,    3'd0);
      chk("reset_out_data",   out_data,   32'd0);
      chk("reset_out_tag",    out_tag,    31'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // Single word, beat k = k*0x11111111.
      for (int k = 0; k < 7; k++) w[k*32 +: 32] = 32'h11111111 * k;
      wq.push_back(w);
      tq.push_back(31'h1234567);
      stream(0, 40);
      chk("single_word_count", word_count, 16'd1);

      // Back-to-back words with in_valid held; mid-word offers must be refused.
      for (int i = 0; i < 3; i++) begin
         wq.push_back(rand_word());
         tq.push_back(31'($urandom));
      end
      stream(0, 60);

      // Backpressure, fixed pattern then random.
      wq.push_back(rand_word());
      tq.push_back(31'($urandom));
      stream(1, 60);
      for (int i = 0; i < 6; i++) begin
         wq.push_back(rand_word());
         tq.push_back(31'($urandom));
      end
      stream(2, 400);

      // Reset mid-word at idx 2.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      SIG_NAMEA = rand_word();
      SIG_NAMEB = 31'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("pre_reset_idx", out_idx, 3'd2);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_reset_out_valid",  out_valid,  1'b0);
      chk("mid_reset_word_count", word_count, 16'd0);
      chk("mid_reset_in_ready",   in_ready,   1'b0);
      reset = 1'b0;
      #1;
      chk("post_reset_in_ready", in_ready, 1'b1);
      m_busy = 1'b0;
      m_wc   = 16'd0;
      @(negedge clk);
      wq.push_back(rand_word());
      tq.push_back(31'($urandom));
      stream(2, 100);

      // Counter wrap: preload 0xFFFF while idle, then send one word.
      force dut.word_count_reg = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.word_count_reg;
      m_wc = 16'hFFFF;
      #1;
      chk("preload_word_count", word_count, 16'hFFFF);
      wq.push_back(rand_word());
      tq.push_back(31'($urandom));
      stream(0, 40);
      chk("wrap_word_count", word_count, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sig_namea_unpack.md
Name: sig_namea_unpack

Overview:
- Inverse of the slice-merge path: consumes one full 224-bit SIG_NAMEA word, plus its SIG_NAMEB sideband, and replays it as a stream of narrow beats.
- Beat order: lower slice [127:0] first, then upper slice [223:128].
- Each beat is tagged with the slice it came from, so the downstream producer-side logic can route lower-slice beats to the 128-bit consumer and upper-slice beats to the 96-bit consumer.
- Sits between the wide-word producer and the per-slice consumers. Valid/ready on both sides.

Parameters:
- WIDE_W, 224: width of SIG_NAMEA. Must be a multiple of BEAT_W.
- SPLIT, 128: bit index of the slice boundary. Lower slice is [SPLIT-1:0]. Must be a multiple of BEAT_W, and 0 < SPLIT < WIDE_W.
- BEAT_W, 32: output beat width.
- FOO, 8: sideband sizing. SIG_NAMEB is [FOO*4-2:0], so 31 bits at the default.
- IDX_W, 3: beat index width. Must satisfy 2**IDX_W >= WIDE_W/BEAT_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- SIG_NAMEA  input  WIDE_W  wide data word
- SIG_NAMEB  input  FOO*4-1  sideband captured with the word
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  BEAT_W  beat payload
- out_tag  output  FOO*4-1  captured SIG_NAMEB, constant for all beats of one word
- out_idx  output  IDX_W  beat index within the word, 0..NBEATS-1
- out_upper  output  1  1 when the beat lies in [WIDE_W-1:SPLIT]
- out_first  output  1  1 on beat 0
- out_last  output  1  1 on beat NBEATS-1
- word_count  output  16  count of fully transmitted words, wraps at 16'hFFFF -> 0

Behaviour:
- Derived constants:
  - NBEATS = WIDE_W/BEAT_W (7 at defaults).
  - LOW_BEATS = SPLIT/BEAT_W (4 at defaults).
- Transfer rules:
  - Input handshake completes when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
- State machine, two states:
  - IDLE: out_valid=0, in_ready=1. On input handshake: capture SIG_NAMEA and SIG_NAMEB, set idx=0, go to SEND.
  - SEND: out_valid=1. On a beat transfer with idx<NBEATS-1: idx increments. On a beat transfer with idx==NBEATS-1, the word count increments and:
    - if in_valid is also high, the next word is captured in the same cycle, idx=0, state stays SEND (zero-bubble back-to-back);
    - otherwise go to IDLE.
- in_ready (combinational): (state==IDLE) || (state==SEND && out_last && out_ready). Forced to 0 while reset=1.
- Beat mapping:
  - out_data = captured[idx*BEAT_W +: BEAT_W].
  - out_upper = (idx >= LOW_BEATS).
  - out_first = (idx==0).
  - out_last = (idx==NBEATS-1).
- Latency: beat 0 is valid on the cycle after the input handshake. A word with no output stalls takes NBEATS cycles.
- Output stability: while out_valid && !out_ready, out_data, out_tag, out_idx, out_upper, out_first and out_last hold stable. SIG_NAMEA and SIG_NAMEB changes have no effect after capture.
- Reset values: state=IDLE, out_valid=0, idx=0, captured data=0, out_tag=0, word_count=0, in_ready=0 during reset.
- Reset mid-word: the word in flight is dropped. out_valid goes 0 on the cycle after reset is sampled high, and no partial-word completion is counted.
- word_count increments only on the last-beat transfer. It wraps 16'hFFFF -> 16'h0000 with no saturation.
- in_valid while in SEND and not on the last beat: ignored (in_ready=0). The producer must hold the word.

Test Plan:
1. Single word, no stalls.
   - Stimulus: out_ready=1; SIG_NAMEA beat k = k*32'h11111111 (beat 6 = 32'h66666666); SIG_NAMEB = 31'h1234567.
   - Required: 7 consecutive beats with out_data 0x00000000..0x66666666; out_upper = 0,0,0,0,1,1,1; out_first only on idx 0; out_last only on idx 6; out_tag = 31'h1234567 on every beat; word_count goes 0 -> 1.
2. Back-to-back words.
   - Stimulus: in_valid held high with words W0 then W1; out_ready=1.
   - Required: 14 consecutive valid beats with no gap; W1 captured in the cycle W0 beat 6 transfers; word_count ends at 2.
3. Backpressure.
   - Stimulus: out_ready toggles 1,0,0,1,... during a word.
   - Required: out_data and out_idx stable through every stall cycle; no beat duplicated or skipped; all 7 beats delivered.
4. Input ignored mid-word.
   - Stimulus: while idx=3, drive in_valid=1 with a different SIG_NAMEA.
   - Required: in_ready=0; remaining beats come from the original word.
5. Reset mid-word.
   - Stimulus: assert reset for 1 cycle at idx=2.
   - Required: next cycle out_valid=0, word_count=0, in_ready=1 after reset deasserts; a following word starts at idx 0.
6. Counter wrap.
   - Stimulus: force word_count to 16'hFFFF (send 65535 words or preload via the bench), then send one more word.
   - Required: word_count = 16'h0000 after its last beat.
